// File: rtl/ahb8_arbiter_if.sv
// ahb8_arbiter_if: 8-bit AHB master/slave bus bundle; down is the arbiter's slave-facing side (no grant)
interface ahb8_arbiter_if #(parameter int ADDR_WID = 32);
  logic [ADDR_WID-1:0] haddr;
  logic hwrite;
  logic hburst;
  logic htrans;
  logic [7:0] hwdata;
  logic hready;
  logic hresp;
  logic [7:0] hrdata;
  logic hgrant;
  modport master (output haddr, hwrite, hburst, htrans, hwdata, input hready, hresp, hrdata, hgrant);
  modport slave (input haddr, hwrite, hburst, htrans, hwdata, output hready, hresp, hrdata, hgrant);
  modport down (output haddr, hwrite, hburst, htrans, hwdata, input hready, hresp, hrdata);
endinterface

// File: rtl/ahb8_arbiter.sv
// ahb8_arbiter: two-master 8-bit AHB arbiter with burst lock and bounded burst length
// AHB8_ARB_RR_EN selects round-robin idle arbitration instead of fixed m0-first priority
module ahb8_arbiter #(
  parameter int ADDR_WID = 32,
  parameter int BURST_MAX = 16,
  parameter int CNT_WID = 8
) (
  input logic hclk,
  input logic hreset_n,
  ahb8_arbiter_if.slave m0,
  ahb8_arbiter_if.slave m1,
  ahb8_arbiter_if.down s
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [CNT_WID:0] BMAX = (CNT_WID+1)'(BURST_MAX);
  localparam logic [CNT_WID-1:0] CMAX = CNT_WID'(BURST_MAX);
  state_t state;
  logic g0, g1;
  logic [CNT_WID-1:0] cnt;
  logic own0, own1, o_htrans, o_hburst, other_req, done, at_max, rel, win0, win1;
  always_comb begin
    own0 = state == OWN0;
    own1 = state == OWN1;
    o_htrans = own0 ? m0.htrans : own1 ? m1.htrans : 1'b0;
    o_hburst = own0 ? m0.hburst : own1 ? m1.hburst : 1'b0;
    other_req = own0 ? m1.htrans : m0.htrans;
    done = o_htrans & s.hready;
    at_max = ({1'b0, cnt} + 1'b1) >= BMAX;
    rel = (done & (!o_hburst | s.hresp | (at_max & other_req))) | (!o_htrans & !o_hburst);
  end
`ifdef AHB8_ARB_RR_EN
  logic last_owner;
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) last_owner <= 1'b0;
    else if (state == IDLE && (win0 || win1)) last_owner <= win1;
  assign win0 = m0.htrans & (!m1.htrans | last_owner);
`else
  assign win0 = m0.htrans;
`endif
  assign win1 = m1.htrans & !win0;
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      state <= IDLE;
      g0 <= 1'b0;
      g1 <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      state <= win0 ? OWN0 : win1 ? OWN1 : IDLE;
      g0 <= win0;
      g1 <= win1;
      cnt <= '0;
    end else if (rel) begin
      state <= IDLE;
      g0 <= 1'b0;
      g1 <= 1'b0;
      cnt <= '0;
    end else if (done) cnt <= at_max ? CMAX : cnt + 1'b1;
  // idle leaves every slave-side output at zero, so nothing leaks between owners
  assign s.haddr = own0 ? m0.haddr : own1 ? m1.haddr : '0;
  assign s.hwrite = own0 ? m0.hwrite : own1 ? m1.hwrite : 1'b0;
  assign s.hburst = o_hburst;
  assign s.htrans = o_htrans;
  assign s.hwdata = own0 ? m0.hwdata : own1 ? m1.hwdata : '0;
  assign m0.hready = own0 & s.hready;
  assign m0.hresp = own0 & s.hresp;
  assign m0.hrdata = own0 ? s.hrdata : '0;
  assign m0.hgrant = g0;
  assign m1.hready = own1 & s.hready;
  assign m1.hresp = own1 & s.hresp;
  assign m1.hrdata = own1 ? s.hrdata : '0;
  assign m1.hgrant = g1;
endmodule

// File: tb/tb_ahb8_arbiter.sv
// tb_ahb8_arbiter: directed self-checking bench for ahb8_arbiter with BURST_MAX=4
module tb_ahb8_arbiter;
  logic hclk, hreset_n;
  int checks, errors, comps;
  ahb8_arbiter_if #(.ADDR_WID(24)) m0_bus();
  ahb8_arbiter_if #(.ADDR_WID(24)) m1_bus();
  ahb8_arbiter_if #(.ADDR_WID(24)) s_bus();
  ahb8_arbiter #(.ADDR_WID(24), .BURST_MAX(4), .CNT_WID(8)) dut (
    .hclk(hclk),
    .hreset_n(hreset_n),
    .m0(m0_bus),
    .m1(m1_bus),
    .s(s_bus)
  );
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic to_neg;
    @(negedge hclk);
    #1;
  endtask
  task automatic to_pos;
    @(posedge hclk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    checks = 0;
    errors = 0;
    hreset_n = 1'b0;
    m0_bus.haddr = 24'hABCDEF; m0_bus.hwrite = 1'b1; m0_bus.hburst = 1'b0; m0_bus.htrans = 1'b1; m0_bus.hwdata = 8'h33;
    m1_bus.haddr = 24'h123456; m1_bus.hwrite = 1'b0; m1_bus.hburst = 1'b0; m1_bus.htrans = 1'b1; m1_bus.hwdata = 8'h44;
    s_bus.hready = 1'b1; s_bus.hresp = 1'b0; s_bus.hrdata = 8'hA5;
    // reset with both masters requesting
    to_neg;
    to_neg;
    check("rst_m0_hgrant", m0_bus.hgrant, 0);
    check("rst_m1_hgrant", m1_bus.hgrant, 0);
    check("rst_s_htrans", s_bus.htrans, 0);
    check("rst_s_haddr", s_bus.haddr, 0);
    check("rst_s_hwdata", s_bus.hwdata, 0);
    check("rst_m0_hready", m0_bus.hready, 0);
    check("rst_m0_hrdata", m0_bus.hrdata, 0);
    to_pos;
    hreset_n = 1'b1;
    to_pos;
    to_neg;
`ifdef AHB8_ARB_RR_EN
    check("rel_m1_hgrant", m1_bus.hgrant, 1);
    check("rel_m0_hgrant", m0_bus.hgrant, 0);
`else
    check("rel_m0_hgrant", m0_bus.hgrant, 1);
    check("rel_m1_hgrant", m1_bus.hgrant, 0);
`endif
    m0_bus.htrans = 1'b0;
    m1_bus.htrans = 1'b0;
    to_pos;
    to_pos;
    to_neg;
    check("quiet_s_htrans", s_bus.htrans, 0);
    check("quiet_m0_hgrant", m0_bus.hgrant, 0);
    // single read by m0
    m0_bus.haddr = 24'hC00500; m0_bus.hwrite = 1'b0; m0_bus.hburst = 1'b0; m0_bus.htrans = 1'b1;
    s_bus.hrdata = 8'h5A;
    to_pos;
    to_neg;
    check("rd_m0_hgrant", m0_bus.hgrant, 1);
    check("rd_s_haddr", s_bus.haddr, 32'hC00500);
    check("rd_s_htrans", s_bus.htrans, 1);
    check("rd_s_hwrite", s_bus.hwrite, 0);
    check("rd_m0_hready", m0_bus.hready, 1);
    check("rd_m0_hrdata", m0_bus.hrdata, 8'h5A);
    check("rd_m1_hready", m1_bus.hready, 0);
    check("rd_m1_hrdata", m1_bus.hrdata, 0);
    to_pos;
    m0_bus.htrans = 1'b0;
    to_neg;
    check("rd_idle_s_htrans", s_bus.htrans, 0);
    check("rd_idle_m0_hgrant", m0_bus.hgrant, 0);
    check("rd_idle_m0_hready", m0_bus.hready, 0);
    // m0 burst while m1 waits: ownership capped at four completions
    m0_bus.hburst = 1'b1; m0_bus.htrans = 1'b1; m0_bus.hwrite = 1'b1; m0_bus.hwdata = 8'h11;
    m1_bus.htrans = 1'b1;
    to_pos;
    comps = 0;
    for (int i = 0; i < 20; i++) begin
      to_neg;
      if (!m0_bus.hgrant) break;
      if (m0_bus.hready) comps++;
      to_pos;
    end
    check("burst_completions", comps, 4);
    check("burst_idle_s_htrans", s_bus.htrans, 0);
    check("burst_idle_m1_hgrant", m1_bus.hgrant, 0);
    to_pos;
    to_neg;
`ifdef AHB8_ARB_RR_EN
    check("burst_regrant_m1", m1_bus.hgrant, 1);
    check("burst_regrant_m0", m0_bus.hgrant, 0);
`else
    check("burst_regrant_m0", m0_bus.hgrant, 1);
    check("burst_regrant_m1", m1_bus.hgrant, 0);
`endif
    m0_bus.htrans = 1'b0; m0_bus.hburst = 1'b0;
    m1_bus.htrans = 1'b0;
    to_pos;
    to_pos;
    // m1 locked burst stalled by wait states while m0 requests
    m1_bus.htrans = 1'b1; m1_bus.hburst = 1'b1; m1_bus.haddr = 24'h000123;
    s_bus.hready = 1'b0;
    to_pos;
    m0_bus.htrans = 1'b1;
    for (int i = 0; i < 5; i++) begin
      to_neg;
      check("wait_m1_hgrant", m1_bus.hgrant, 1);
      check("wait_m0_hready", m0_bus.hready, 0);
      check("wait_m1_hready", m1_bus.hready, 0);
      check("wait_cnt", dut.cnt, 0);
      to_pos;
    end
    // error on a completed transfer drops m1's lock
    m0_bus.htrans = 1'b0;
    s_bus.hready = 1'b1; s_bus.hresp = 1'b1;
    to_neg;
    check("err_m1_hresp", m1_bus.hresp, 1);
    check("err_m1_hready", m1_bus.hready, 1);
    check("err_m0_hresp", m0_bus.hresp, 0);
    to_pos;
    s_bus.hresp = 1'b0;
    to_neg;
    check("err_m1_hgrant", m1_bus.hgrant, 0);
    check("err_s_htrans", s_bus.htrans, 0);
    to_pos;
    to_neg;
    check("err_regrant_m1", m1_bus.hgrant, 1);
    // asynchronous reset in the middle of m1's burst
    #2;
    hreset_n = 1'b0;
    #1;
    check("arst_m1_hgrant", m1_bus.hgrant, 0);
    check("arst_s_htrans", s_bus.htrans, 0);
    check("arst_m1_hready", m1_bus.hready, 0);
    m1_bus.htrans = 1'b0; m1_bus.hburst = 1'b0;
    to_pos;
    hreset_n = 1'b1;
    to_pos;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb8_arbiter.md
Name: ahb8_arbiter

Overview:
Two-master arbiter for the shrinked 8-bit AHB fabric. Shares one slave-side bus (FSB8 controller plus on-chip peripheral decode) between the CPU (master 0) and a central DMA engine (master 1). It sits between the masters and the address decoder. It sequences bus ownership with burst-lock support and a bounded burst length so that neither master can starve the other.

Parameters:
ADDR_WID, 32, address width (24 when MMU is disabled)
BURST_MAX, 16, max accepted transfers per ownership while the other master is waiting; range 1..255
CNT_WID, 8, width of the burst counter

Ports:
hclk  input  1  system clock
hreset_n  input  1  asynchronous active-low reset
m0_haddr  input  ADDR_WID  CPU address
m0_hwrite  input  1  CPU write
m0_hburst  input  1  CPU lock/continue request
m0_htrans  input  1  CPU transfer request
m0_hwdata  input  8  CPU write data
m0_hready  output  1  CPU transfer complete
m0_hresp  output  1  CPU error
m0_hrdata  output  8  CPU read data
m0_hgrant  output  1  CPU owns bus
m1_* (haddr, hwrite, hburst, htrans, hwdata, hready, hresp, hrdata, hgrant)  same as m0_*, DMA master
s_haddr  output  ADDR_WID  slave address
s_hwrite  output  1  slave write
s_hburst  output  1  slave burst
s_htrans  output  1  slave transfer request
s_hwdata  output  8  slave write data
s_hready  input  1  slave complete
s_hresp  input  1  slave error
s_hrdata  input  8  slave read data

Behaviour:
- Clock and reset: one clock, hclk. hreset_n is asynchronous active-low.
- Transfer rule: a transfer completes in a cycle where the owner's htrans=1 and s_hready=1. Each master holds its signals stable until its hready=1.
- FSM states: IDLE, OWN0, OWN1. State register, grant register and burst counter are reset asynchronously to IDLE, grants 0, count 0.
- Reset values of outputs: all s_* outputs are 0. m*_hready=0, m*_hresp=0, m*_hrdata=0, m*_hgrant=0.
- IDLE:
  - s_htrans is forced 0.
  - If m0_htrans=1, next state is OWN0. Otherwise, if m1_htrans=1, next state is OWN1. Fixed priority applies.
  - The grant takes effect the following cycle, so there is one cycle of arbitration latency.
- OWNx:
  - s_* outputs are driven combinationally from master x. s_hready, s_hresp and s_hrdata are routed to master x. mx_hgrant=1.
  - The non-owner sees hready=0, hresp=0, hrdata=0.
- Burst counter:
  - Increments on each completed transfer in OWNx, saturating at BURST_MAX.
  - Clears on every state change.
- Release from OWNx to IDLE when any of the following holds:
  - (a) A transfer completes and mx_hburst=0.
  - (b) mx_htrans=0 and mx_hburst=0.
  - (c) A transfer completes, count+1 ≥ BURST_MAX, and the other master's htrans=1.
  - (d) s_hresp=1 on a completed transfer. The error is forwarded to the owner and the lock is dropped.
- On forced release (c), the owner's further requests wait in IDLE arbitration like any other request.
- Simultaneous requests in IDLE follow the fixed priority above unless the optional feature is compiled in.
- A request that drops before its grant is ignored; IDLE holds.
- Reset mid-transfer: all grants drop immediately (asynchronously). The in-flight transfer is abandoned, and the masters must reissue it.
- Address width mismatch is not permitted: all haddr ports are ADDR_WID.

Optional Feature:
- Macro: AHB8_ARB_RR_EN.
- When defined: IDLE arbitration is round-robin. A 1-bit last_owner register (reset 0) is kept. On simultaneous requests, the master that is not last_owner wins. last_owner updates on every entry to OWNx.
- When undefined: fixed priority, master 0 first. last_owner logic is absent.

Test Plan:
1. Reset: hold hreset_n=0 with both htrans=1 -> all outputs 0, state IDLE. Release -> m0_hgrant=1 one cycle later.
2. Single transfers: m0 read of 0xC0_0500 with m0_hburst=0, s_hready=1, s_hrdata=0x5A -> m0_hrdata=0x5A, m0_hready=1. Next cycle is IDLE with s_htrans=0.
3. Burst fairness: m0 burst (hburst=1), m1_htrans=1 throughout, BURST_MAX=4 -> exactly 4 m0 completions, then IDLE, then OWN0 again under fixed priority. With AHB8_ARB_RR_EN defined -> OWN1 instead.
4. Error: m1 owns the bus with hburst=1 and the slave returns s_hresp=1 on a completed transfer -> m1_hresp=1 that cycle, then IDLE, and m1 loses the lock.
5. Wait states: m1 owns the bus and s_hready=0 for 5 cycles -> m1 stays granted, counter unchanged, m0_hready=0 throughout.
6. Async reset mid-burst: hreset_n low mid-cycle -> grants and s_htrans drop without waiting for a clock edge.
